// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a 4x4 matrix keypad one column at a time. Each key is debounced
//   on press and on release. An accepted key produces a one-cycle key_valid
//   strobe and shifts into a two-digit display register.
//
//   Build option: KEYSCAN_REPEAT_EN
//     When this macro is defined, a held key re-strobes every REPEAT_COUNT
//     cycles. When it is not defined, each press gives exactly one strobe.
//
//   Ports
//     clk        system clock, rising edge
//     reset      asynchronous active-low reset
//     rows[3:0]  row sense, synchronous to clk, active-low
//     cols[3:0]  column drive, one-hot active-low
//     key_code   hex code of the last accepted key
//     key_valid  one-cycle strobe per accepted key
//     digit_new  most recent accepted key (right digit)
//     digit_old  previous accepted key (left digit)
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   SCAN       | rotate columns, sample rows in last tick of each column
//   PRESS_DB   | column frozen, count stable-low cycles of latched row
//   HELD       | key accepted, wait for latched row to go high
//   RELEASE_DB | count stable-high cycles of latched row before rescanning

module keypad_scan_ctrl #(
   parameter int SCAN_TICKS     = 4,
   parameter int DEBOUNCE_COUNT = 8,
   parameter int REPEAT_COUNT   = 125
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int MAX_A   = (SCAN_TICKS > DEBOUNCE_COUNT) ? SCAN_TICKS : DEBOUNCE_COUNT;
   localparam int MAX_CNT = (MAX_A > REPEAT_COUNT) ? MAX_A : REPEAT_COUNT;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_COUNT - 1);
`ifdef KEYSCAN_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_COUNT - 1);
`endif

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       digit_new_q, digit_new_d;
   logic [3:0]       digit_old_q, digit_old_d;

   logic             any_low;
   logic [1:0]       low_row;
   logic             row_sel;
   logic [3:0]       key_now;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h2;
         4'b00_10: k = 4'h3;
         4'b00_11: k = 4'hA;
         4'b01_00: k = 4'h4;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h6;
         4'b01_11: k = 4'hB;
         4'b10_00: k = 4'h7;
         4'b10_01: k = 4'h8;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hC;
         4'b11_00: k = 4'hE;
         4'b11_01: k = 4'h0;
         4'b11_10: k = 4'hF;
         default:  k = 4'hD;
      endcase
      return k;
   endfunction

   // When several rows are low together, the lowest-numbered row wins.
   always_comb begin
      any_low = ~&rows;
      low_row = 2'd3;
      if (!rows[0])      low_row = 2'd0;
      else if (!rows[1]) low_row = 2'd1;
      else if (!rows[2]) low_row = 2'd2;
   end

   assign row_sel = rows[row_q];
   assign key_now = key_map(row_q, col_q);

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      cnt_d       = cnt_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      digit_new_d = digit_new_q;
      digit_old_d = digit_old_q;

      case (state_q)
         SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (any_low) begin
                  row_d   = low_row;
                  state_d = PRESS_DB;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESS_DB: begin
            if (row_sel) begin
               state_d = SCAN;
               col_d   = col_q + 2'd1;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d     = HELD;
               cnt_d       = '0;
               key_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (row_sel) begin
               state_d = RELEASE_DB;
               cnt_d   = '0;
            end
`ifdef KEYSCAN_REPEAT_EN
            else if (cnt_q == REP_LAST) begin
               cnt_d       = '0;
               key_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         RELEASE_DB: begin
            if (!row_sel) begin
               // The key bounced back down, so return to HELD. The repeat
               // interval starts over from zero.
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = SCAN;
               col_d   = col_q + 2'd1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = SCAN;
            cnt_d   = '0;
         end
      endcase

      // Every strobe, first press or repeat, shifts the display digits.
      if (key_valid_d) begin
         key_code_d  = key_now;
         digit_old_d = digit_new_q;
         digit_new_d = key_now;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         cnt_q       <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         digit_new_q <= 4'h0;
         digit_old_q <= 4'h0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         digit_new_q <= digit_new_d;
         digit_old_q <= digit_old_d;
      end
   end

   assign cols      = ~(4'b0001 << col_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign digit_new = digit_new_q;
   assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl. A behavioural keypad matrix drives rows
// from cols and a set of pressed keys. Repeat expectations depend on
// KEYSCAN_REPEAT_EN.
module tb_keypad_scan_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   logic [15:0] pressed;
   int          checks;
   int          errors;
   logic [3:0]  log_q[$];

`ifdef KEYSCAN_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   keypad_scan_ctrl #(
      .SCAN_TICKS    (4),
      .DEBOUNCE_COUNT(8),
      .REPEAT_COUNT  (20)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rows     (rows),
      .cols     (cols),
      .key_code (key_code),
      .key_valid(key_valid),
      .digit_new(digit_new),
      .digit_old(digit_old)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key shorts its row to its column.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   always @(negedge clk)
      if (reset && key_valid) log_q.push_back(key_code);

   typedef struct {
      int         r;
      int         c;
      int         hold;
      logic [3:0] code;
      logic [3:0] dnew;
      logic [3:0] dold;
      logic [3:0] cols_exp;
      logic [3:0] cols_next;
      int         n_exp;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input int r, input int c);
      pressed[r*4+c] = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_kv(input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (key_valid) seen = 1'b1;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   function automatic int count_code(input int from, input logic [3:0] code);
      int n;
      n = 0;
      for (int i = from; i < log_q.size(); i++)
         if (log_q[i] == code) n++;
      return n;
   endfunction

   initial begin
      int  base;
      bit  early;

      checks  = 0;
      errors  = 0;
      pressed = '0;
      reset   = 1'b0;

      vecs[0] = '{1, 2, 40, 4'h6, 4'h6, 4'h0, 4'b1011, 4'b0111, (REP ? 3 : 1)};
      vecs[1] = '{1, 1, 15, 4'h5, 4'h5, 4'h6, 4'b1101, 4'b1011, 1};
      vecs[2] = '{0, 3, 15, 4'hA, 4'hA, 4'h5, 4'b0111, 4'b1110, 1};
      vecs[3] = '{3, 1, 15, 4'h0, 4'h0, 4'hA, 4'b1101, 4'b1011, 1};
      vecs[4] = '{3, 0, 15, 4'hE, 4'hE, 4'h0, 4'b1110, 4'b1101, 1};
      vecs[5] = '{3, 3, 15, 4'hD, 4'hD, 4'hE, 4'b0111, 4'b1110, 1};
      vecs[6] = '{2, 2, 15, 4'h9, 4'h9, 4'hD, 4'b1011, 4'b0111, 1};

      // Values held while in reset.
      repeat (2) @(negedge clk);
      chk("rst_cols", cols, 4'b1110);
      chk("rst_kv", key_valid, 1'b0);
      chk("rst_code", key_code, 4'h0);
      chk("rst_dnew", digit_new, 4'h0);
      chk("rst_dold", digit_old, 4'h0);

      // Latency: key 1 is down from reset release. Column 0 is sampled in
      // cycle 3, so the strobe appears in cycle 12.
      pressed = 16'h0001;
      reset   = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk);
         if (n == 11) chk("lat_kv_pre", key_valid, 1'b0);
         if (n == 12) begin
            chk("lat_kv", key_valid, 1'b1);
            chk("lat_code", key_code, 4'h1);
         end
         if (n == 13) chk("lat_kv_post", key_valid, 1'b0);
      end
      pressed = '0;
      repeat (20) @(negedge clk);

      // Bounce: key 1 goes high for one cycle during PRESS_DB, which aborts
      // the attempt. The scan continues at column 1 and returns to
      // column 0, sampling it in cycle 22. The strobe appears in cycle 31.
      pressed = 16'h0001;
      do_reset();
      base  = log_q.size();
      early = 1'b0;
      for (int n = 1; n <= 45; n++) begin
         @(negedge clk);
         if (n <= 30 && key_valid) early = 1'b1;
         if (n == 31) chk("bnc_kv", key_valid, 1'b1);
         if (n == 6)  pressed = '0;
         if (n == 7)  pressed = 16'h0001;
         if (n == 37) pressed = '0;
      end
      chk("bnc_no_early", 32'(early), 32'd0);
      chk("bnc_count", 32'(log_q.size() - base), 32'd1);
      chk("bnc_code", key_code, 4'h1);

      // Reset during press debounce: the pending key is discarded.
      pressed = 16'h0001;
      do_reset();
      repeat (8) @(negedge clk);
      reset   = 1'b0;
      pressed = '0;
      @(negedge clk);
      reset = 1'b1;
      base  = log_q.size();
      repeat (40) @(negedge clk);
      chk("rstdb_none", 32'(log_q.size() - base), 32'd0);

      // Table of single presses, starting from cleared digits.
      do_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         base = log_q.size();
         press(vecs[i].r, vecs[i].c);
         wait_kv(40, "tbl_strobe");
         chk("tbl_code", key_code, vecs[i].code);
         chk("tbl_dnew", digit_new, vecs[i].dnew);
         chk("tbl_dold", digit_old, vecs[i].dold);
         repeat (vecs[i].hold) @(negedge clk);
         chk("tbl_cols_held", cols, vecs[i].cols_exp);
         pressed = '0;
         repeat (8) @(negedge clk);
         chk("tbl_cols_rel8", cols, vecs[i].cols_exp);
         @(negedge clk);
         chk("tbl_cols_rel9", cols, vecs[i].cols_next);
         repeat (10) @(negedge clk);
         chk("tbl_strobes", 32'(log_q.size() - base), 32'(vecs[i].n_exp));
      end

      // Key 0 is held while key 9 is pressed. Key 9 must not strobe until
      // key 0 has been released and the scan reaches column 2.
      base = log_q.size();
      press(3, 1);
      wait_kv(40, "k0_strobe");
      chk("k0_code", key_code, 4'h0);
      press(2, 2);
      repeat (35) @(negedge clk);
      chk("k9_blocked", 32'(count_code(base, 4'h9)), 32'd0);
      pressed[3*4+1] = 1'b0;
      wait_kv(60, "k9_strobe");
      chk("k9_code", key_code, 4'h9);
      chk("k9_dnew", digit_new, 4'h9);
      chk("k9_dold", digit_old, 4'h0);
      repeat (5) @(negedge clk);
      pressed = '0;
      repeat (20) @(negedge clk);
      chk("k09_first", 32'(log_q[base]), 32'h0);
      chk("k9_once", 32'(count_code(base, 4'h9)), 32'd1);

      // Key F held for 70 cycles after acceptance.
      base = log_q.size();
      press(3, 2);
      wait_kv(40, "f_strobe");
      repeat (70) @(negedge clk);
      pressed = '0;
      repeat (20) @(negedge clk);
      chk("f_count", 32'(log_q.size() - base), 32'(REP ? 4 : 1));
      chk("f_all_f", 32'(count_code(base, 4'hF)), 32'(REP ? 4 : 1));
      chk("f_dnew", digit_new, 4'hF);
      chk("f_dold", digit_old, REP ? 4'hF : 4'h9);

      // Asynchronous reset while a key is held.
      press(1, 1);
      wait_kv(40, "mh_strobe");
      repeat (5) @(negedge clk);
      #3 reset = 1'b0;
      #1;
      chk("mh_cols", cols, 4'b1110);
      chk("mh_kv", key_valid, 1'b0);
      chk("mh_code", key_code, 4'h0);
      chk("mh_dnew", digit_new, 4'h0);
      chk("mh_dold", digit_old, 4'h0);
      pressed = '0;
      @(negedge clk);
      reset = 1'b1;
      base  = log_q.size();
      repeat (40) @(negedge clk);
      chk("mh_none", 32'(log_q.size() - base), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
